// File: rtl/serial_pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator: FSM encoding, the default idle level
// and the len clamp helper.
package serial_pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic DEFAULT_IDLE_LEVEL = 1'b1;

  // A len of 0, or any len above the word width, selects the full word.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/serial_pattern_gen_if.sv
// Control and stream bundle between a sequencer (master) and serial_pattern_gen (slave).
interface serial_pattern_gen_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] rep;
  logic             out;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, len, rep,
    input  out, valid, busy, done
  );

  modport slave (
    input  start, abort, pattern, len, rep,
    output out, valid, busy, done
  );
endinterface

// File: rtl/serial_pattern_gen_piso_shift_reg.sv
// Parallel-in serial-out register; q is a registered LSB that falls back to IDLE_LEVEL
// on any cycle that neither loads nor shifts.
module piso_shift_reg #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q
);

  logic [WIDTH-2:0] sr_reg;
  logic             q_reg;
  logic [WIDTH-2:0] sr_shifted;

  // The bit after q lives in sr_reg[0]; vacated positions fill with the idle level.
  assign sr_shifted = (WIDTH-1)'({IDLE_LEVEL, sr_reg} >> 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_reg <= {(WIDTH-1){IDLE_LEVEL}};
      q_reg  <= IDLE_LEVEL;
    end else if (load) begin
      sr_reg <= d[WIDTH-1:1];
      q_reg  <= d[0];
    end else if (shift) begin
      sr_reg <= sr_shifted;
      q_reg  <= sr_reg[0];
    end else begin
      q_reg  <= IDLE_LEVEL;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial pattern generator: latches a word on start and streams it LSB-first,
// replaying it rep extra times, with registered valid/busy/done status.
module serial_pattern_gen
  import serial_pattern_gen_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   LEN_W      = 4,
  parameter int   CNT_W      = 4,
  parameter logic IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
  input  logic              clk,
  input  logic              reset,
  serial_pattern_gen_if.slave bus
);

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0] rep_cnt_reg, rep_cnt_next;
  logic [LEN_W-1:0] len_lat_reg, len_lat_next;
  logic [CNT_W-1:0] rep_lat_reg, rep_lat_next;
  logic [WIDTH-1:0] pattern_lat_reg, pattern_lat_next;
  logic             valid_reg, valid_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic             sr_load;
  logic             sr_shift;
  logic [WIDTH-1:0] sr_d;
  logic             sr_q;
  logic [LEN_W-1:0] len_eff_in;
  logic             last_bit;

  assign len_eff_in = LEN_W'(eff_len(32'(bus.len), WIDTH));
  assign last_bit   = (bit_cnt_reg == (len_lat_reg - LEN_W'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      bit_cnt_reg     <= '0;
      rep_cnt_reg     <= '0;
      len_lat_reg     <= '0;
      rep_lat_reg     <= '0;
      pattern_lat_reg <= '0;
      valid_reg       <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      rep_cnt_reg     <= rep_cnt_next;
      len_lat_reg     <= len_lat_next;
      rep_lat_reg     <= rep_lat_next;
      pattern_lat_reg <= pattern_lat_next;
      valid_reg       <= valid_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    rep_cnt_next     = rep_cnt_reg;
    len_lat_next     = len_lat_reg;
    rep_lat_next     = rep_lat_reg;
    pattern_lat_next = pattern_lat_reg;
    valid_next       = 1'b0;
    busy_next        = 1'b0;
    done_next        = 1'b0;
    sr_load          = 1'b0;
    sr_shift         = 1'b0;
    sr_d             = pattern_lat_reg;

    case (state_reg)
      ST_IDLE: begin
        // abort outranks a simultaneous start
        if (bus.start && !bus.abort) begin
          state_next       = ST_SHIFT;
          pattern_lat_next = bus.pattern;
          len_lat_next     = len_eff_in;
          rep_lat_next     = bus.rep;
          bit_cnt_next     = '0;
          rep_cnt_next     = '0;
          sr_load          = 1'b1;
          sr_d             = bus.pattern;
          valid_next       = 1'b1;
          busy_next        = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (bus.abort) begin
          state_next   = ST_IDLE;
          bit_cnt_next = '0;
          rep_cnt_next = '0;
        end else if (last_bit) begin
          // Compare before increment so rep_cnt can never wrap.
          if (rep_cnt_reg < rep_lat_reg) begin
            sr_load      = 1'b1;
            bit_cnt_next = '0;
            rep_cnt_next = rep_cnt_reg + CNT_W'(1);
            valid_next   = 1'b1;
            busy_next    = 1'b1;
          end else begin
            state_next   = ST_DONE;
            bit_cnt_next = '0;
            rep_cnt_next = '0;
            done_next    = 1'b1;
          end
        end else begin
          sr_shift     = 1'b1;
          bit_cnt_next = bit_cnt_reg + LEN_W'(1);
          valid_next   = 1'b1;
          busy_next    = 1'b1;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  piso_shift_reg #(
    .WIDTH      (WIDTH),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (sr_load),
    .shift (sr_shift),
    .d     (sr_d),
    .q     (sr_q)
  );

  assign bus.out   = sr_q;
  assign bus.valid = valid_reg;
  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;

endmodule
